// File: rtl/acorn_step_ctrl.sv
// acorn_step_ctrl: phase sequencer for the bit-serial ACORN-128 core.
// Drives one step command per cycle and captures the tag.
module acorn_step_ctrl #(
  parameter int LEN_W       = 16,
  parameter int INIT_STEPS  = 1792,
  parameter int FINAL_STEPS = 768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key_in,
  input  logic [127:0]     iv_in,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [LEN_W-1:0] pt_len,
  input  logic             ad_valid,
  input  logic             ad_bit,
  output logic             ad_ready,
  input  logic             pt_valid,
  input  logic             pt_bit,
  output logic             pt_ready,
  input  logic             ks_bit,
  output logic             step_en,
  output logic             m_bit,
  output logic             ca,
  output logic             cb,
  output logic             ct_valid,
  output logic             ct_bit,
  output logic             core_clr,
  output logic [127:0]     tag_out,
  output logic             tag_valid,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_INIT, S_AD,
    S_AD_PAD, S_PT, S_PT_PAD, S_FINAL
  } state_t;

  localparam logic [10:0] INIT_LAST  = 11'(INIT_STEPS - 1);
  localparam logic [10:0] FINAL_LAST = 11'(FINAL_STEPS - 1);
  localparam logic [10:0] TAG_FIRST  = 11'(FINAL_STEPS - 128);
  localparam logic [10:0] PAD_LAST   = 11'd255;
  localparam logic [10:0] PAD_HALF   = 11'd128;
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  state_t           state_q, state_d;
  logic [10:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0] bits_q, bits_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     iv_q, iv_d;
  logic [LEN_W-1:0] ad_len_q, ad_len_d;
  logic [LEN_W-1:0] pt_len_q, pt_len_d;
  logic [127:0]     tag_q, tag_d;
  logic             tv_q, tv_d;

  // Next-state, counters, tag capture and per-cycle step command
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    key_d    = key_q;
    iv_d     = iv_q;
    ad_len_d = ad_len_q;
    pt_len_d = pt_len_q;
    tag_d    = tag_q;
    tv_d     = tv_q;
    step_en  = 1'b0;
    m_bit    = 1'b0;
    ca       = 1'b0;
    cb       = 1'b0;
    ad_ready = 1'b0;
    pt_ready = 1'b0;
    ct_valid = 1'b0;
    ct_bit   = 1'b0;
    core_clr = 1'b0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d    = key_in;
          iv_d     = iv_in;
          ad_len_d = ad_len;
          pt_len_d = pt_len;
          tv_d     = 1'b0;
          cnt_d    = '0;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        core_clr = 1'b1;
        cnt_d    = '0;
        state_d  = S_INIT;
      end
      S_INIT: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        if (cnt_q < 11'd128)
          m_bit = key_q[cnt_q[6:0]];
        else if (cnt_q < 11'd256)
          m_bit = iv_q[cnt_q[6:0]];
        else if (cnt_q == 11'd256)
          m_bit = ~key_q[0];
        else
          m_bit = key_q[cnt_q[6:0]];
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = (ad_len_q == '0) ? S_AD_PAD : S_AD;
        end
      end
      S_AD: begin
        ca       = 1'b1;
        cb       = 1'b1;
        ad_ready = 1'b1;
        step_en  = ad_valid;
        m_bit    = ad_bit;
        if (ad_valid) begin
          bits_d = bits_q + ONE_L;
          if (bits_q == ad_len_q - ONE_L) begin
            bits_d  = '0;
            state_d = S_AD_PAD;
          end
        end
      end
      S_AD_PAD: begin
        step_en = 1'b1;
        m_bit   = (cnt_q == '0);
        ca      = (cnt_q < PAD_HALF);
        cb      = 1'b1;
        cnt_d   = cnt_q + 11'd1;
        if (cnt_q == PAD_LAST) begin
          cnt_d   = '0;
          state_d = (pt_len_q == '0) ? S_PT_PAD : S_PT;
        end
      end
      S_PT: begin
        ca       = 1'b1;
        pt_ready = 1'b1;
        step_en  = pt_valid;
        m_bit    = pt_bit;
        ct_valid = pt_valid;
        ct_bit   = pt_bit ^ ks_bit;
        if (pt_valid) begin
          bits_d = bits_q + ONE_L;
          if (bits_q == pt_len_q - ONE_L) begin
            bits_d  = '0;
            state_d = S_PT_PAD;
          end
        end
      end
      S_PT_PAD: begin
        step_en = 1'b1;
        m_bit   = (cnt_q == '0);
        ca      = (cnt_q < PAD_HALF);
        cnt_d   = cnt_q + 11'd1;
        if (cnt_q == PAD_LAST) begin
          cnt_d   = '0;
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        if (cnt_q >= TAG_FIRST)
          tag_d[cnt_q[6:0] - TAG_FIRST[6:0]] = ks_bit;
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == FINAL_LAST) begin
          cnt_d   = '0;
          tv_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset aborts at once: no command leaves in the reset cycle
    if (rst) begin
      step_en  = 1'b0;
      m_bit    = 1'b0;
      ca       = 1'b0;
      cb       = 1'b0;
      ad_ready = 1'b0;
      pt_ready = 1'b0;
      ct_valid = 1'b0;
      ct_bit   = 1'b0;
      core_clr = 1'b0;
      busy     = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bits_q   <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      ad_len_q <= '0;
      pt_len_q <= '0;
      tag_q    <= '0;
      tv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      ad_len_q <= ad_len_d;
      pt_len_q <= pt_len_d;
      tag_q    <= tag_d;
      tv_q     <= tv_d;
    end
  end

  assign tag_out   = tag_q;
  assign tag_valid = tv_q;

endmodule

// File: tb/tb_acorn_step_ctrl.sv
// tb_acorn_step_ctrl: directed bench for acorn_step_ctrl.
// A toy core supplies ks_bit; a spec-order replay gives the expected tag.
module tb_acorn_step_ctrl;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key_in, iv_in;
  logic [15:0]  ad_len, pt_len;
  logic         ad_valid, ad_bit, ad_ready;
  logic         pt_valid, pt_bit, pt_ready;
  logic         ks_bit, step_en, m_bit, ca, cb;
  logic         ct_valid, ct_bit, core_clr;
  logic [127:0] tag_out;
  logic         tag_valid, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acorn_step_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .key_in(key_in), .iv_in(iv_in),
    .ad_len(ad_len), .pt_len(pt_len),
    .ad_valid(ad_valid), .ad_bit(ad_bit),
    .ad_ready(ad_ready),
    .pt_valid(pt_valid), .pt_bit(pt_bit),
    .pt_ready(pt_ready),
    .ks_bit(ks_bit), .step_en(step_en),
    .m_bit(m_bit), .ca(ca), .cb(cb),
    .ct_valid(ct_valid), .ct_bit(ct_bit),
    .core_clr(core_clr), .tag_out(tag_out),
    .tag_valid(tag_valid), .busy(busy)
  );

  function automatic logic ks_f(input logic [63:0] s);
    return s[5] ^ (s[20] & s[41]) ^ s[62] ^ s[33];
  endfunction

  function automatic logic [63:0] step_f(
    input logic [63:0] s, input logic m,
    input logic a, input logic b);
    logic fb;
    fb = s[63] ^ s[47] ^ (a & s[12]) ^ (b & s[30])
       ^ m ^ (s[9] & s[25]);
    return {s[62:0], fb};
  endfunction

  logic [63:0] cs = '0;
  always @(posedge clk) begin
    if (core_clr) cs <= '0;
    else if (step_en) cs <= step_f(cs, m_bit, ca, cb);
  end
  assign ks_bit = ks_f(cs);

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ref_run(
    input logic [127:0] k, input logic [127:0] v,
    input int adl, input int ptl,
    input logic [15:0] ad, input logic [15:0] pt,
    output logic [127:0] tag, output logic [15:0] ct);
    logic [63:0] s;
    logic m;
    s = '0;
    tag = '0;
    ct = '0;
    for (int i = 0; i < 1792; i++) begin
      if (i < 128) m = k[i];
      else if (i < 256) m = v[i-128];
      else if (i == 256) m = ~k[0];
      else m = k[i%128];
      s = step_f(s, m, 1'b1, 1'b1);
    end
    for (int i = 0; i < adl; i++)
      s = step_f(s, ad[i], 1'b1, 1'b1);
    for (int i = 0; i < 256; i++)
      s = step_f(s, i == 0, i < 128, 1'b1);
    for (int i = 0; i < ptl; i++) begin
      ct[i] = pt[i] ^ ks_f(s);
      s = step_f(s, pt[i], 1'b1, 1'b0);
    end
    for (int i = 0; i < 256; i++)
      s = step_f(s, i == 0, i < 128, 1'b0);
    for (int i = 0; i < 768; i++) begin
      if (i >= 640) tag[i-640] = ks_f(s);
      s = step_f(s, 1'b0, 1'b1, 1'b1);
    end
  endtask

  typedef struct packed {
    logic se, m, ca, cb, clr;
    logic adr, adv, ptr, ctv;
    logic busy, tv;
  } rec_t;

  rec_t        tr [0:4999];
  int          done;
  logic [15:0] got_ct;

  // One message: cycle 0 presents start; logs until tag_valid
  task automatic run_msg(
    input logic [127:0] k, input logic [127:0] v,
    input int adl, input int ptl,
    input logic [15:0] ad, input logic [15:0] pt,
    input bit toggle);
    int n, ai, pi;
    n = 0; ai = 0; pi = 0;
    done = -1;
    got_ct = '0;
    @(negedge clk);
    key_in = k; iv_in = v;
    ad_len = 16'(adl); pt_len = 16'(ptl);
    start = 1'b1;
    while (done < 0 && n < 5000) begin
      ad_valid = toggle ? ((n % 2) == 1) : 1'b1;
      ad_bit   = (ai < 16) ? ad[ai] : 1'b0;
      pt_valid = 1'b1;
      pt_bit   = (pi < 16) ? pt[pi] : 1'b0;
      #1;
      tr[n] = '{step_en, m_bit, ca, cb, core_clr,
                ad_ready, ad_valid, pt_ready,
                ct_valid, busy, tag_valid};
      if (ad_valid && ad_ready) ai++;
      if (pt_valid && pt_ready) begin
        if (pi < 16) got_ct[pi] = ct_bit;
        pi++;
      end
      if (tag_valid && n > 0) done = n;
      n++;
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    ad_valid = 1'b0;
    pt_valid = 1'b0;
    if (done < 0) chk("timeout", 0, 1);
  endtask

  typedef struct {
    int         cyc;
    logic [6:0] e;
  } vec_t;

  vec_t         vt [22];
  logic [127:0] k01, exp_tag, tag2;
  logic [15:0]  exp_ct;
  int           cnt_a, cnt_b, cnt_c, last_ad;
  bit           hit;

  initial begin
    vt[0]  = '{0,    7'b0000000};
    vt[1]  = '{1,    7'b0000110};
    vt[2]  = '{2,    7'b1111010};
    vt[3]  = '{3,    7'b1011010};
    vt[4]  = '{10,   7'b1111010};
    vt[5]  = '{130,  7'b1111010};
    vt[6]  = '{138,  7'b1111010};
    vt[7]  = '{258,  7'b1011010};
    vt[8]  = '{259,  7'b1011010};
    vt[9]  = '{266,  7'b1111010};
    vt[10] = '{1793, 7'b1011010};
    vt[11] = '{1794, 7'b1111010};
    vt[12] = '{1795, 7'b1011010};
    vt[13] = '{1921, 7'b1011010};
    vt[14] = '{1922, 7'b1001010};
    vt[15] = '{2049, 7'b1001010};
    vt[16] = '{2050, 7'b1110010};
    vt[17] = '{2051, 7'b1010010};
    vt[18] = '{2178, 7'b1000010};
    vt[19] = '{2306, 7'b1011010};
    vt[20] = '{3073, 7'b1011010};
    vt[21] = '{3074, 7'b0000001};
    k01 = {16{8'h01}};

    // T1: reset with start held
    rst = 1'b1; start = 1'b1;
    key_in = '1; iv_in = '1;
    ad_len = '0; pt_len = '0;
    ad_valid = 1'b0; ad_bit = 1'b0;
    pt_valid = 1'b0; pt_bit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_out%0d", i),
          {step_en, m_bit, ca, cb, ad_ready, pt_ready,
           ct_valid, core_clr, busy, tag_valid}, 0);
    end
    chk("rst_tag", tag_out, 0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;

    // T2/T3: zero-length message, trace by table
    run_msg(k01, k01, 0, 0, 16'h0, 16'h0, 1'b0);
    ref_run(k01, k01, 0, 0, 16'h0, 16'h0, exp_tag, exp_ct);
    chk("t2_latency", done, 3074);
    if (done >= 3074) begin
      for (int i = 0; i < 22; i++)
        chk($sformatf("vec%0d", i),
            {tr[vt[i].cyc].se, tr[vt[i].cyc].m,
             tr[vt[i].cyc].ca, tr[vt[i].cyc].cb,
             tr[vt[i].cyc].clr, tr[vt[i].cyc].busy,
             tr[vt[i].cyc].tv}, vt[i].e);
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int c = 0; c <= done; c++) begin
        cnt_a += tr[c].se;
        cnt_b += tr[c].clr;
        cnt_c += tr[c].adr | tr[c].ptr;
      end
      chk("t2_steps", cnt_a, 3072);
      chk("t2_clr", cnt_b, 1);
      chk("t2_ready", cnt_c, 0);
    end
    chk("t2_tag", tag_out, exp_tag);
    tag2 = tag_out;

    // T4: 8 AD bits with ad_valid toggling
    run_msg(128'h0123456789abcdef_fedcba9876543210,
            128'h1111_2222_3333_4444_5555_6666_7777_8888,
            8, 0, 16'h00b5, 16'h0, 1'b1);
    ref_run(128'h0123456789abcdef_fedcba9876543210,
            128'h1111_2222_3333_4444_5555_6666_7777_8888,
            8, 0, 16'h00b5, 16'h0, exp_tag, exp_ct);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; last_ad = 0;
    if (done > 0) begin
      for (int c = 0; c <= done; c++) begin
        if (tr[c].adr && tr[c].se) begin
          cnt_a++;
          last_ad = c;
        end
        if (tr[c].adr && !tr[c].adv) begin
          cnt_b++;
          if (tr[c].se) cnt_c++;
        end
        if (tr[c].adr && !(tr[c].ca && tr[c].cb)) cnt_c++;
      end
    end
    chk("t4_ad_steps", cnt_a, 8);
    chk("t4_stalled", cnt_b > 0, 1);
    chk("t4_stall_bad", cnt_c, 0);
    cnt_a = 0; cnt_b = 0;
    if (last_ad > 0 && last_ad + 256 < 5000) begin
      for (int c = last_ad + 1; c <= last_ad + 256; c++) begin
        cnt_a += tr[c].m;
        cnt_b += tr[c].ca;
      end
      chk("t4_pad_m0", tr[last_ad+1].m, 1);
      chk("t4_pad_ca127", tr[last_ad+128].ca, 1);
      chk("t4_pad_ca128", tr[last_ad+129].ca, 0);
    end
    chk("t4_pad_mcnt", cnt_a, 1);
    chk("t4_pad_cacnt", cnt_b, 128);
    chk("t4_tag", tag_out, exp_tag);

    // T5: 16 PT bits, ciphertext and tag against replay
    run_msg(128'hdeadbeef_0badf00d_cafebabe_13579bdf,
            128'h02468ace_fdb97531_a5a5a5a5_5a5a5a5a,
            8, 16, 16'h003c, 16'ha5a5, 1'b0);
    ref_run(128'hdeadbeef_0badf00d_cafebabe_13579bdf,
            128'h02468ace_fdb97531_a5a5a5a5_5a5a5a5a,
            8, 16, 16'h003c, 16'ha5a5, exp_tag, exp_ct);
    chk("t5_ct", got_ct, exp_ct);
    cnt_a = 0; cnt_b = 0;
    if (done > 0) begin
      for (int c = 0; c <= done; c++) begin
        cnt_a += tr[c].ctv;
        if (tr[c].se && !tr[c].cb) cnt_b++;
      end
    end
    chk("t5_ctv_cnt", cnt_a, 16);
    chk("t5_cb0_steps", cnt_b, 272);
    chk("t5_tag", tag_out, exp_tag);

    // T6: reset in AD, then a clean rerun
    @(negedge clk);
    key_in = k01; iv_in = k01;
    ad_len = 16'd8; pt_len = 16'd0;
    ad_valid = 1'b0; start = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      #1;
      if (ad_ready) hit = 1'b1;
      else begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("t6_reach_ad", hit, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_cyc", {step_en, busy, ad_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_after", {busy, tag_valid, ad_ready}, 0);
    run_msg(k01, k01, 0, 0, 16'h0, 16'h0, 1'b0);
    chk("t6_latency", done, 3074);
    chk("t6_tag", tag_out, tag2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
